// File: rtl/sdram_arb.sv
// sdram_arb: two-port arbiter in front of a single-access SDRAM controller.
// Each port makes level requests (byte or 16-bit, read or write) that are
// serialised onto the controller handshake (ram_rd/ram_wr, ram_busy).
// Port-1 addresses are offset by P1_BASE; port-0 addresses pass through.
// Optional feature: define SDRAM_ARB_RR_EN for round-robin arbitration
// between simultaneous requests; the default build is fixed priority
// with port 0 winning.
module sdram_arb #(
    parameter logic [24:0] P1_BASE = 25'h0000000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        p0_req,
    input  logic [24:0] p0_addr,
    input  logic        p0_we,
    input  logic        p0_word,
    input  logic [15:0] p0_din,
    output logic        p0_ack,
    output logic [15:0] p0_dout,
    input  logic        p1_req,
    input  logic [24:0] p1_addr,
    input  logic        p1_we,
    input  logic        p1_word,
    input  logic [15:0] p1_din,
    output logic        p1_ack,
    output logic [15:0] p1_dout,
    output logic [24:0] ram_addr,
    output logic        ram_rd,
    output logic        ram_wr,
    output logic        ram_word,
    output logic [15:0] ram_din,
    input  logic [15:0] ram_dout,
    input  logic        ram_busy
);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

    state_t state;
    state_t state_next;
    logic   grant_q;    // port owning the access in flight (0 or 1)
    logic   we_q;       // direction of the access in flight
    logic   grant_p1;   // arbitration result for a new access
    logic   start;      // IDLE accepts a new access this cycle

`ifdef SDRAM_ARB_RR_EN
    logic   last_grant; // port granted most recently

    // Round-robin: on contention, favour the port not granted last.
    always_comb begin
        grant_p1 = p1_req & (~p0_req | ~last_grant);
    end

    // Remember the last granted port; reset points at port 1 so the
    // first contention goes to port 0.
    always_ff @(posedge clk) begin
        if (reset) begin
            last_grant <= 1'b1;
        end else if (start) begin
            last_grant <= grant_p1;
        end
    end
`else
    // Fixed priority: port 0 always wins a tie.
    always_comb begin
        grant_p1 = p1_req & ~p0_req;
    end
`endif

    // A new access starts only when the controller is idle and no ack is
    // still showing, so a client holding req through its ack cycle is not
    // served twice.
    assign start = (state == IDLE) && !ram_busy && (p0_req || p1_req)
                   && !p0_ack && !p1_ack;

    // Command strobes are decoded from the state, so they are low in every
    // state but ISSUE and can never be high together.
    assign ram_rd = (state == ISSUE) && !we_q;
    assign ram_wr = (state == ISSUE) &&  we_q;

    // State register.
    // NOTE: sequential state uses non-blocking (<=) so every flop samples
    // pre-edge values; blocking here would create order-dependent races.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic.
    // NOTE: state_next is assigned a default first so no path leaves it
    // unassigned, which would infer a latch.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start)     state_next = ISSUE;
            ISSUE:   if (ram_busy)  state_next = WAIT;
            WAIT:    if (!ram_busy) state_next = DONE;
            DONE:                   state_next = IDLE;
            default:                state_next = IDLE;
        endcase
    end

    // Datapath: latch the granted request, capture read data, pulse ack.
    always_ff @(posedge clk) begin
        if (reset) begin
            grant_q  <= 1'b0;
            we_q     <= 1'b0;
            ram_addr <= '0;
            ram_word <= 1'b0;
            ram_din  <= '0;
            p0_ack   <= 1'b0;
            p1_ack   <= 1'b0;
            p0_dout  <= '0;
            p1_dout  <= '0;
        end else begin
            // Ack is registered from DONE, so it shows in the first IDLE cycle.
            p0_ack <= (state == DONE) && !grant_q;
            p1_ack <= (state == DONE) &&  grant_q;

            // Request fields are held from ISSUE entry through DONE.
            if (start) begin
                grant_q <= grant_p1;
                if (grant_p1) begin
                    we_q     <= p1_we;
                    ram_addr <= p1_addr + P1_BASE;
                    ram_word <= p1_word;
                    ram_din  <= p1_din;
                end else begin
                    we_q     <= p0_we;
                    ram_addr <= p0_addr;
                    ram_word <= p0_word;
                    ram_din  <= p0_din;
                end
            end

            // Reads only: writes leave the port's dout untouched.
            if ((state == WAIT) && !ram_busy && !we_q) begin
                if (grant_q) begin
                    p1_dout <= ram_dout;
                end else begin
                    p0_dout <= ram_dout;
                end
            end
        end
    end

endmodule

// File: tb/tb_sdram_arb.sv
// tb_sdram_arb: directed self-checking bench for sdram_arb (P1_BASE = 4).
// The controller side is emulated by the service task, which raises
// ram_busy a chosen number of cycles after a command appears.
module tb_sdram_arb;

    logic        clk = 1'b0;
    logic        reset;
    logic        p0_req, p1_req;
    logic [24:0] p0_addr, p1_addr;
    logic        p0_we, p1_we, p0_word, p1_word;
    logic [15:0] p0_din, p1_din;
    logic        p0_ack, p1_ack;
    logic [15:0] p0_dout, p1_dout;
    logic [24:0] ram_addr;
    logic        ram_rd, ram_wr, ram_word;
    logic [15:0] ram_din, ram_dout;
    logic        ram_busy;

    int checks = 0;
    int passed = 0;

    // Results of the most recent service() call.
    int          s_ack_port, s_ack_cycle, s_rd_rises, s_wr_rises, s_rd_hi, s_overlap;
    logic        s_stable;
    logic [24:0] s_addr;
    logic        s_word;
    logic [15:0] s_din;

    sdram_arb #(.P1_BASE(25'h4)) dut (
        .clk      (clk),
        .reset    (reset),
        .p0_req   (p0_req),
        .p0_addr  (p0_addr),
        .p0_we    (p0_we),
        .p0_word  (p0_word),
        .p0_din   (p0_din),
        .p0_ack   (p0_ack),
        .p0_dout  (p0_dout),
        .p1_req   (p1_req),
        .p1_addr  (p1_addr),
        .p1_we    (p1_we),
        .p1_word  (p1_word),
        .p1_din   (p1_din),
        .p1_ack   (p1_ack),
        .p1_dout  (p1_dout),
        .ram_addr (ram_addr),
        .ram_rd   (ram_rd),
        .ram_wr   (ram_wr),
        .ram_word (ram_word),
        .ram_din  (ram_din),
        .ram_dout (ram_dout),
        .ram_busy (ram_busy)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Emulated controller: once a command is seen, busy stays low for
    // 'hold' more samples, then high for 'nbusy' samples. Returns in the
    // ack cycle (cycle 0 = cycle the caller presented the request).
    task automatic service(input int hold, input int nbusy);
        int cyc = 0;
        int n = 0;
        bit issued = 0;
        bit prev_rd = ram_rd;
        bit prev_wr = ram_wr;
        s_ack_port = -1; s_ack_cycle = -1; s_rd_rises = 0; s_wr_rises = 0;
        s_rd_hi = 0; s_overlap = 0; s_stable = 1'b1;
        s_addr = 'x; s_word = 1'bx; s_din = 'x;
        while (s_ack_port < 0 && cyc < 400) begin
            step();
            cyc++;
            if (ram_rd && ram_wr) s_overlap++;
            if (ram_rd && !prev_rd) s_rd_rises++;
            if (ram_wr && !prev_wr) s_wr_rises++;
            if (ram_rd) s_rd_hi++;
            prev_rd = ram_rd;
            prev_wr = ram_wr;
            if (!issued && (ram_rd || ram_wr)) begin
                issued = 1; n = 0;
                s_addr = ram_addr; s_word = ram_word; s_din = ram_din;
            end else if (issued) begin
                n++;
                if (ram_addr !== s_addr || ram_word !== s_word || ram_din !== s_din)
                    s_stable = 1'b0;
            end
            if (issued) ram_busy = (n >= hold) && (n < hold + nbusy);
            if (p0_ack || p1_ack) begin
                s_ack_port  = (p0_ack && p1_ack) ? 2 : (p1_ack ? 1 : 0);
                s_ack_cycle = cyc;
            end
        end
        ram_busy = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        step(); step();
        checks++;
        if ({ram_rd, ram_wr, p0_ack, p1_ack} !== 4'b0) $display("FAIL reset_strobes: got %b expected 0000", {ram_rd, ram_wr, p0_ack, p1_ack});
        else passed++;
        checks++;
        if ({p0_dout, p1_dout} !== 32'h0) $display("FAIL reset_dout: got %h expected 00000000", {p0_dout, p1_dout});
        else passed++;
        checks++;
        if ({ram_addr, ram_din} !== 41'h0) $display("FAIL reset_addr_din: got %h/%h expected 0/0", ram_addr, ram_din);
        else passed++;
        reset = 1'b0;
        step();
    endtask

    task automatic test_read();
        p0_addr = 25'h0000100; p0_we = 1'b0; p0_word = 1'b1; p0_din = 16'h1234;
        ram_dout = 16'hBEEF; p0_req = 1'b1;
        service(1, 5);
        p0_req = 1'b0;
        checks++;
        if (s_ack_port !== 0 || s_ack_cycle !== 9) $display("FAIL read_ack: got port %0d cycle %0d expected port 0 cycle 9", s_ack_port, s_ack_cycle);
        else passed++;
        checks++;
        if (s_rd_rises !== 1 || s_wr_rises !== 0) $display("FAIL read_strobes: got rd %0d wr %0d pulses expected 1/0", s_rd_rises, s_wr_rises);
        else passed++;
        checks++;
        if (p0_dout !== 16'hBEEF) $display("FAIL read_dout: got %h expected beef", p0_dout);
        else passed++;
        checks++;
        if (s_addr !== 25'h0000100 || s_word !== 1'b1 || !s_stable) $display("FAIL read_addr: got %h word %b stable %b expected 0000100 1 1", s_addr, s_word, s_stable);
        else passed++;
        step();
        checks++;
        if (p0_ack !== 1'b0) $display("FAIL read_ack_width: got ack %b one cycle later expected 0", p0_ack);
        else passed++;
    endtask

    task automatic test_hold_req();
        p0_addr = 25'h0000200; p0_we = 1'b0; p0_word = 1'b1;
        ram_dout = 16'h1111; p0_req = 1'b1;
        service(0, 1);
        checks++;
        if (s_ack_port !== 0 || s_ack_cycle !== 4) $display("FAIL hold_ack: got port %0d cycle %0d expected port 0 cycle 4", s_ack_port, s_ack_cycle);
        else passed++;
        step();  // req still high while ack is showing
        checks++;
        if (ram_rd !== 1'b0) $display("FAIL hold_no_reissue: got ram_rd %b expected 0", ram_rd);
        else passed++;
        p0_req = 1'b0;
        step();
        checks++;
        if ({ram_rd, ram_wr} !== 2'b00) $display("FAIL hold_idle: got rd/wr %b expected 00", {ram_rd, ram_wr});
        else passed++;
    endtask

    task automatic test_write();
        p1_addr = 25'h0000010; p1_we = 1'b0; p1_word = 1'b1;
        ram_dout = 16'h5A5A; p1_req = 1'b1;
        service(1, 2);
        p1_req = 1'b0;
        checks++;
        if (s_ack_port !== 1 || s_addr !== 25'h0000014 || p1_dout !== 16'h5A5A) $display("FAIL p1_read: got port %0d addr %h dout %h expected 1 0000014 5a5a", s_ack_port, s_addr, p1_dout);
        else passed++;
        step();
        p1_addr = 25'h1FFFFFE; p1_we = 1'b1; p1_word = 1'b0; p1_din = 16'h00A5;
        ram_dout = 16'hFFFF; p1_req = 1'b1;
        service(1, 1);
        p1_req = 1'b0;
        checks++;
        if (s_ack_port !== 1 || s_addr !== 25'h0000002) $display("FAIL write_wrap: got port %0d addr %h expected 1 0000002", s_ack_port, s_addr);
        else passed++;
        checks++;
        if (s_wr_rises !== 1 || s_rd_rises !== 0 || s_overlap !== 0) $display("FAIL write_strobes: got wr %0d rd %0d overlap %0d expected 1 0 0", s_wr_rises, s_rd_rises, s_overlap);
        else passed++;
        checks++;
        if (s_word !== 1'b0 || s_din !== 16'h00A5 || !s_stable) $display("FAIL write_fields: got word %b din %h stable %b expected 0 00a5 1", s_word, s_din, s_stable);
        else passed++;
        checks++;
        if (p1_dout !== 16'h5A5A) $display("FAIL write_dout_kept: got %h expected 5a5a", p1_dout);
        else passed++;
        step();
    endtask

    task automatic test_arbitration();
        int order[4];
        int exp_order[4];
`ifdef SDRAM_ARB_RR_EN
        exp_order = '{0, 1, 0, 1};
`else
        exp_order = '{0, 0, 0, 0};
`endif
        p0_addr = 25'h0000300; p0_we = 1'b0; p0_word = 1'b1;
        p1_addr = 25'h0000400; p1_we = 1'b0; p1_word = 1'b1;
        ram_dout = 16'h0000;
        p0_req = 1'b1; p1_req = 1'b1;
        for (int k = 0; k < 4; k++) begin
            service(1, 1);
            order[k] = s_ack_port;
        end
        for (int k = 0; k < 4; k++) begin
            checks++;
            if (order[k] !== exp_order[k]) $display("FAIL arb_order[%0d]: got port %0d expected %0d", k, order[k], exp_order[k]);
            else passed++;
        end
        p0_req = 1'b0;
        service(1, 1);
        p1_req = 1'b0;
        checks++;
        if (s_ack_port !== 1 || s_addr !== 25'h0000404) $display("FAIL arb_p1_not_dropped: got port %0d addr %h expected 1 0000404", s_ack_port, s_addr);
        else passed++;
        step();
    endtask

    task automatic test_long_issue();
        p0_addr = 25'h0000500; p0_we = 1'b0; p0_word = 1'b1;
        ram_dout = 16'hC0DE; p0_req = 1'b1;
        service(20, 2);
        p0_req = 1'b0;
        checks++;
        if (s_rd_rises !== 1 || s_rd_hi !== 21) $display("FAIL long_rd: got %0d pulses %0d high cycles expected 1 21", s_rd_rises, s_rd_hi);
        else passed++;
        checks++;
        if (s_ack_port !== 0 || s_ack_cycle !== 25 || p0_dout !== 16'hC0DE) $display("FAIL long_ack: got port %0d cycle %0d dout %h expected 0 25 c0de", s_ack_port, s_ack_cycle, p0_dout);
        else passed++;
        step();
    endtask

    task automatic test_reset_mid();
        p0_addr = 25'h0000600; p0_we = 1'b0; p0_word = 1'b1; p0_req = 1'b1;
        step();
        checks++;
        if (ram_rd !== 1'b1) $display("FAIL mid_issue: got ram_rd %b expected 1", ram_rd);
        else passed++;
        ram_busy = 1'b1;
        step();
        checks++;
        if (ram_rd !== 1'b0) $display("FAIL mid_wait: got ram_rd %b expected 0", ram_rd);
        else passed++;
        reset = 1'b1; p0_req = 1'b0;
        step();
        reset = 1'b0;
        checks++;
        if ({ram_addr, ram_din, p0_dout, p1_dout} !== 73'h0 || {ram_rd, ram_wr, p0_ack, p1_ack} !== 4'b0)
            $display("FAIL mid_cleared: got addr %h din %h dout %h/%h strobes %b expected all 0", ram_addr, ram_din, p0_dout, p1_dout, {ram_rd, ram_wr, p0_ack, p1_ack});
        else passed++;
        p1_addr = 25'h0000020; p1_we = 1'b0; p1_word = 1'b1; p1_req = 1'b1;
        for (int k = 0; k < 3; k++) begin
            step();
            checks++;
            if ({ram_rd, ram_wr, p0_ack, p1_ack} !== 4'b0) $display("FAIL mid_blocked[%0d]: got rd/wr/ack %b expected 0000", k, {ram_rd, ram_wr, p0_ack, p1_ack});
            else passed++;
        end
        ram_busy = 1'b0; ram_dout = 16'h7777;
        service(1, 1);
        p1_req = 1'b0;
        checks++;
        if (s_ack_port !== 1 || s_addr !== 25'h0000024 || p1_dout !== 16'h7777) $display("FAIL mid_next: got port %0d addr %h dout %h expected 1 0000024 7777", s_ack_port, s_addr, p1_dout);
        else passed++;
        step();
    endtask

    initial begin
        reset = 1'b1;
        p0_req = 1'b0; p0_addr = '0; p0_we = 1'b0; p0_word = 1'b0; p0_din = '0;
        p1_req = 1'b0; p1_addr = '0; p1_we = 1'b0; p1_word = 1'b0; p1_din = '0;
        ram_dout = '0; ram_busy = 1'b0;
        test_reset();
        test_read();
        test_hold_req();
        test_write();
        test_arbitration();
        test_long_issue();
        test_reset_mid();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
